// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multi-cycle control sequencer for the shared-memory MIPS datapath.
// Walks each instruction through IF/ID/EX/MEM/WB and decodes per-state datapath
// controls from the current state plus the opcode/funct latched during ID.
// Optional performance counters are built only when MC_PERF_CNT_EN is defined.
module mc_control_fsm #(
    parameter int OP_W    = 6,
    parameter int FUNCT_W = 6
`ifdef MC_PERF_CNT_EN
    ,
    parameter int CNT_W   = 32
`endif
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [OP_W-1:0]    instr_op_i,
    input  logic [FUNCT_W-1:0] funct_i,
    input  logic               mem_ready_i,
    output logic               pc_write_o,
    output logic               branch_o,
    output logic [2:0]         branch_type_o,
    output logic [1:0]         pc_src_o,
    output logic               ir_write_o,
    output logic               iord_o,
    output logic               mem_read_o,
    output logic               mem_write_o,
    output logic               reg_write_o,
    output logic [1:0]         reg_dst_o,
    output logic [1:0]         mem_to_reg_o,
    output logic               alu_src_a_o,
    output logic [1:0]         alu_src_b_o,
    output logic [4:0]         alu_op_o,
    output logic [2:0]         state_o,
    output logic               illegal_o
`ifdef MC_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]   cycle_cnt_o,
    output logic [CNT_W-1:0]   retired_cnt_o
`endif
);

    typedef enum logic [2:0] {
        ST_IF   = 3'd0,
        ST_ID   = 3'd1,
        ST_EX   = 3'd2,
        ST_MEM  = 3'd3,
        ST_WB   = 3'd4,
        ST_TRAP = 3'd7
    } state_t;

    localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'h00);
    localparam logic [OP_W-1:0] OP_J     = OP_W'(6'h02);
    localparam logic [OP_W-1:0] OP_JAL   = OP_W'(6'h03);
    localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'h04);
    localparam logic [OP_W-1:0] OP_BNE   = OP_W'(6'h05);
    localparam logic [OP_W-1:0] OP_BLT   = OP_W'(6'h06);
    localparam logic [OP_W-1:0] OP_BLE   = OP_W'(6'h07);
    localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'h08);
    localparam logic [OP_W-1:0] OP_ORI   = OP_W'(6'h0D);
    localparam logic [OP_W-1:0] OP_LUI   = OP_W'(6'h0F);
    localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'h23);
    localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'h2B);

    localparam logic [FUNCT_W-1:0] FN_JR = FUNCT_W'(6'h08);

    // ALU control classes shared with the single-cycle decoder.
    localparam logic [4:0] ALU_ADD   = 5'd0;
    localparam logic [4:0] ALU_SUB   = 5'd1;
    localparam logic [4:0] ALU_OR    = 5'd2;
    localparam logic [4:0] ALU_LUI   = 5'd3;
    localparam logic [4:0] ALU_RTYPE = 5'd4;

    state_t             state_q, state_d;
    logic [OP_W-1:0]    op_q, op_d;
    logic [FUNCT_W-1:0] funct_q, funct_d;

    // IR is valid throughout ID, so the opcode/funct are captured there and
    // held for the later states of the same instruction.
    always_comb begin
        op_d    = op_q;
        funct_d = funct_q;
        if (state_q == ST_ID) begin
            op_d    = instr_op_i;
            funct_d = funct_i;
        end
    end

    // State and latched instruction fields; reset aborts any instruction in flight.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IF;
            op_q    <= '0;
            funct_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            funct_q <= funct_d;
        end
    end

    // Next-state and control decode; everything is forced low while reset is held
    // so memory requests stop the instant reset asserts.
    always_comb begin
        state_d       = state_q;
        pc_write_o    = 1'b0;
        branch_o      = 1'b0;
        branch_type_o = 3'd0;
        pc_src_o      = 2'd0;
        ir_write_o    = 1'b0;
        iord_o        = 1'b0;
        mem_read_o    = 1'b0;
        mem_write_o   = 1'b0;
        reg_write_o   = 1'b0;
        reg_dst_o     = 2'd0;
        mem_to_reg_o  = 2'd0;
        alu_src_a_o   = 1'b0;
        alu_src_b_o   = 2'd0;
        alu_op_o      = ALU_ADD;
        illegal_o     = 1'b0;

        case (state_q)
            ST_IF: begin
                mem_read_o  = 1'b1;
                alu_src_b_o = 2'd1;
                if (mem_ready_i) begin
                    ir_write_o = 1'b1;
                    pc_write_o = 1'b1;
                    state_d    = ST_ID;
                end
            end
            ST_ID: begin
                alu_src_b_o = 2'd3;
                case (instr_op_i)
                    OP_J: begin
                        pc_write_o = 1'b1;
                        pc_src_o   = 2'd2;
                        state_d    = ST_IF;
                    end
                    OP_JAL: begin
                        pc_write_o   = 1'b1;
                        pc_src_o     = 2'd2;
                        reg_write_o  = 1'b1;
                        reg_dst_o    = 2'd2;
                        mem_to_reg_o = 2'd2;
                        state_d      = ST_IF;
                    end
                    OP_RTYPE, OP_ADDI, OP_ORI, OP_LUI, OP_LW, OP_SW,
                    OP_BEQ, OP_BNE, OP_BLT, OP_BLE: begin
                        state_d = ST_EX;
                    end
                    default: state_d = ST_TRAP;
                endcase
            end
            ST_EX: begin
                case (op_q)
                    OP_RTYPE: begin
                        if (funct_q == FN_JR) begin
                            pc_write_o = 1'b1;
                            pc_src_o   = 2'd3;
                            state_d    = ST_IF;
                        end else begin
                            alu_src_a_o = 1'b1;
                            alu_src_b_o = 2'd0;
                            alu_op_o    = ALU_RTYPE;
                            state_d     = ST_WB;
                        end
                    end
                    OP_ADDI: begin
                        alu_src_b_o = 2'd2;
                        state_d     = ST_WB;
                    end
                    OP_ORI: begin
                        alu_src_b_o = 2'd2;
                        alu_op_o    = ALU_OR;
                        state_d     = ST_WB;
                    end
                    OP_LUI: begin
                        alu_src_b_o = 2'd2;
                        alu_op_o    = ALU_LUI;
                        state_d     = ST_WB;
                    end
                    OP_LW, OP_SW: begin
                        alu_src_b_o = 2'd2;
                        state_d     = ST_MEM;
                    end
                    OP_BEQ, OP_BNE, OP_BLT, OP_BLE: begin
                        alu_src_a_o = 1'b1;
                        alu_src_b_o = 2'd0;
                        alu_op_o    = ALU_SUB;
                        branch_o    = 1'b1;
                        pc_src_o    = 2'd1;
                        state_d     = ST_IF;
                        case (op_q)
                            OP_BEQ:  branch_type_o = 3'd1;
                            OP_BNE:  branch_type_o = 3'd2;
                            OP_BLE:  branch_type_o = 3'd3;
                            default: branch_type_o = 3'd4;
                        endcase
                    end
                    default: state_d = ST_TRAP;
                endcase
            end
            ST_MEM: begin
                iord_o = 1'b1;
                if (op_q == OP_LW) begin
                    mem_read_o = 1'b1;
                end else begin
                    mem_write_o = 1'b1;
                end
                if (mem_ready_i) begin
                    state_d = (op_q == OP_LW) ? ST_WB : ST_IF;
                end
            end
            ST_WB: begin
                reg_write_o = 1'b1;
                if (op_q == OP_RTYPE) begin
                    reg_dst_o = 2'd1;
                end else if (op_q == OP_LW) begin
                    mem_to_reg_o = 2'd1;
                end
                state_d = ST_IF;
            end
            ST_TRAP: begin
                illegal_o = 1'b1;
            end
            default: state_d = ST_TRAP;
        endcase

        if (!rst_i) begin
            state_d       = ST_IF;
            pc_write_o    = 1'b0;
            branch_o      = 1'b0;
            branch_type_o = 3'd0;
            pc_src_o      = 2'd0;
            ir_write_o    = 1'b0;
            iord_o        = 1'b0;
            mem_read_o    = 1'b0;
            mem_write_o   = 1'b0;
            reg_write_o   = 1'b0;
            reg_dst_o     = 2'd0;
            mem_to_reg_o  = 2'd0;
            alu_src_a_o   = 1'b0;
            alu_src_b_o   = 2'd0;
            alu_op_o      = ALU_ADD;
            illegal_o     = 1'b0;
        end
    end

    assign state_o = state_q;

`ifdef MC_PERF_CNT_EN
    logic [CNT_W-1:0] cycle_cnt_q, retired_cnt_q;
    logic             retire;

    assign retire = (state_d == ST_IF) &&
                    ((state_q == ST_ID) || (state_q == ST_EX) ||
                     (state_q == ST_MEM) || (state_q == ST_WB));

    // Cycle counter freezes once trapped; retire counter bumps on every return to IF.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cycle_cnt_q   <= '0;
            retired_cnt_q <= '0;
        end else begin
            if (state_q != ST_TRAP) begin
                cycle_cnt_q <= cycle_cnt_q + 1'b1;
            end
            if (retire) begin
                retired_cnt_q <= retired_cnt_q + 1'b1;
            end
        end
    end

    assign cycle_cnt_o   = cycle_cnt_q;
    assign retired_cnt_o = retired_cnt_q;
`endif

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb_mc_control_fsm: table-driven check of the multi-cycle control sequencer,
// plus hand-written trap, asynchronous-reset and (optionally) counter sequences.
module tb_mc_control_fsm;

    localparam logic [4:0] ADD = 5'd0;
    localparam logic [4:0] SUB = 5'd1;
    localparam logic [4:0] ORA = 5'd2;
    localparam logic [4:0] LUI = 5'd3;
    localparam logic [4:0] RTY = 5'd4;

    typedef struct packed {
        logic [2:0] st;
        logic       pcW;
        logic       br;
        logic [2:0] bt;
        logic [1:0] ps;
        logic       irW;
        logic       iord;
        logic       mr;
        logic       mw;
        logic       rw;
        logic [1:0] rd;
        logic [1:0] m2r;
        logic       asa;
        logic [1:0] asb;
        logic [4:0] aop;
        logic       ill;
    } ctrl_t;

    typedef struct {
        logic [5:0] op;
        logic [5:0] funct;
        logic       ready;
        ctrl_t      exp;
    } vec_t;

    logic       clk;
    logic       rstN;
    logic [5:0] instrOp;
    logic [5:0] funct;
    logic       memReady;
    logic       pcWrite, branch, irWrite, iord, memRead, memWrite, regWrite;
    logic       aluSrcA, illegal;
    logic [2:0] branchType, state;
    logic [1:0] pcSrc, regDst, memToReg, aluSrcB;
    logic [4:0] aluOp;
`ifdef MC_PERF_CNT_EN
    logic [31:0] cycleCnt, retiredCnt;
`endif

    int checkCnt = 0;
    int passCnt  = 0;
    vec_t vecs[$];

    mc_control_fsm dut (
        .clk_i         (clk),
        .rst_i         (rstN),
        .instr_op_i    (instrOp),
        .funct_i       (funct),
        .mem_ready_i   (memReady),
        .pc_write_o    (pcWrite),
        .branch_o      (branch),
        .branch_type_o (branchType),
        .pc_src_o      (pcSrc),
        .ir_write_o    (irWrite),
        .iord_o        (iord),
        .mem_read_o    (memRead),
        .mem_write_o   (memWrite),
        .reg_write_o   (regWrite),
        .reg_dst_o     (regDst),
        .mem_to_reg_o  (memToReg),
        .alu_src_a_o   (aluSrcA),
        .alu_src_b_o   (aluSrcB),
        .alu_op_o      (aluOp),
        .state_o       (state),
        .illegal_o     (illegal)
`ifdef MC_PERF_CNT_EN
        ,
        .cycle_cnt_o   (cycleCnt),
        .retired_cnt_o (retiredCnt)
`endif
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic ctrl_t mk(input logic [2:0] st, input logic pcW, input logic br,
                                 input logic [2:0] bt, input logic [1:0] ps, input logic irW,
                                 input logic io, input logic mr, input logic mw, input logic rw,
                                 input logic [1:0] rd, input logic [1:0] m2r, input logic asa,
                                 input logic [1:0] asb, input logic [4:0] aop, input logic ill);
        ctrl_t c;
        c = '{st, pcW, br, bt, ps, irW, io, mr, mw, rw, rd, m2r, asa, asb, aop, ill};
        return c;
    endfunction

    function automatic void addVec(input logic [5:0] op, input logic [5:0] fn,
                                   input logic rdy, input ctrl_t e);
        vec_t v;
        v.op = op; v.funct = fn; v.ready = rdy; v.exp = e;
        vecs.push_back(v);
    endfunction

    task automatic applyStimulus(input logic [5:0] op, input logic [5:0] fn, input logic rdy);
        @(negedge clk);
        instrOp  = op;
        funct    = fn;
        memReady = rdy;
    endtask

    task automatic checkOutput(input string name, input ctrl_t exp);
        ctrl_t act;
        #1;
        act = '{state, pcWrite, branch, branchType, pcSrc, irWrite, iord, memRead, memWrite,
                regWrite, regDst, memToReg, aluSrcA, aluSrcB, aluOp, illegal};
        checkCnt++;
        if (act !== exp) begin
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            passCnt++;
        end
    endtask

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCnt++;
        if (act !== exp) begin
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            passCnt++;
        end
    endtask

    // Directed vectors, then trap / reset corner cases.
    initial begin
        ctrl_t cIF1, cIF0, cID, cZero, cTrap;
        cIF1  = mk(0,1,0,0,0,1,0,1,0,0,0,0,0,1,ADD,0);
        cIF0  = mk(0,0,0,0,0,0,0,1,0,0,0,0,0,1,ADD,0);
        cID   = mk(1,0,0,0,0,0,0,0,0,0,0,0,0,3,ADD,0);
        cZero = mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0,ADD,0);
        cTrap = mk(7,0,0,0,0,0,0,0,0,0,0,0,0,0,ADD,1);

        // ADD
        addVec(6'h00, 6'h20, 1, cIF1);
        addVec(6'h00, 6'h20, 1, cID);
        addVec(6'h00, 6'h20, 1, mk(2,0,0,0,0,0,0,0,0,0,0,0,1,0,RTY,0));
        addVec(6'h00, 6'h20, 1, mk(4,0,0,0,0,0,0,0,0,1,1,0,0,0,ADD,0));
        // LW with 2 fetch waits and 3 memory waits: 10 cycles
        addVec(6'h23, 6'h00, 0, cIF0);
        addVec(6'h23, 6'h00, 0, cIF0);
        addVec(6'h23, 6'h00, 1, cIF1);
        addVec(6'h23, 6'h00, 1, cID);
        addVec(6'h23, 6'h00, 0, mk(2,0,0,0,0,0,0,0,0,0,0,0,0,2,ADD,0));
        addVec(6'h23, 6'h00, 0, mk(3,0,0,0,0,0,1,1,0,0,0,0,0,0,ADD,0));
        addVec(6'h23, 6'h00, 0, mk(3,0,0,0,0,0,1,1,0,0,0,0,0,0,ADD,0));
        addVec(6'h23, 6'h00, 0, mk(3,0,0,0,0,0,1,1,0,0,0,0,0,0,ADD,0));
        addVec(6'h23, 6'h00, 1, mk(3,0,0,0,0,0,1,1,0,0,0,0,0,0,ADD,0));
        addVec(6'h23, 6'h00, 1, mk(4,0,0,0,0,0,0,0,0,1,0,1,0,0,ADD,0));
        // BLT
        addVec(6'h06, 6'h00, 1, cIF1);
        addVec(6'h06, 6'h00, 1, cID);
        addVec(6'h06, 6'h00, 1, mk(2,0,1,4,1,0,0,0,0,0,0,0,1,0,SUB,0));
        // JAL
        addVec(6'h03, 6'h00, 1, cIF1);
        addVec(6'h03, 6'h00, 1, mk(1,1,0,0,2,0,0,0,0,1,2,2,0,3,ADD,0));
        // J
        addVec(6'h02, 6'h00, 1, cIF1);
        addVec(6'h02, 6'h00, 1, mk(1,1,0,0,2,0,0,0,0,0,0,0,0,3,ADD,0));
        // SW
        addVec(6'h2B, 6'h00, 1, cIF1);
        addVec(6'h2B, 6'h00, 1, cID);
        addVec(6'h2B, 6'h00, 1, mk(2,0,0,0,0,0,0,0,0,0,0,0,0,2,ADD,0));
        addVec(6'h2B, 6'h00, 1, mk(3,0,0,0,0,0,1,0,1,0,0,0,0,0,ADD,0));
        // JR
        addVec(6'h00, 6'h08, 1, cIF1);
        addVec(6'h00, 6'h08, 1, cID);
        addVec(6'h00, 6'h08, 1, mk(2,1,0,0,3,0,0,0,0,0,0,0,0,0,ADD,0));
        // BEQ, BNE, BLE
        addVec(6'h04, 6'h00, 1, cIF1);
        addVec(6'h04, 6'h00, 1, cID);
        addVec(6'h04, 6'h00, 1, mk(2,0,1,1,1,0,0,0,0,0,0,0,1,0,SUB,0));
        addVec(6'h05, 6'h00, 1, cIF1);
        addVec(6'h05, 6'h00, 1, cID);
        addVec(6'h05, 6'h00, 1, mk(2,0,1,2,1,0,0,0,0,0,0,0,1,0,SUB,0));
        addVec(6'h07, 6'h00, 1, cIF1);
        addVec(6'h07, 6'h00, 1, cID);
        addVec(6'h07, 6'h00, 1, mk(2,0,1,3,1,0,0,0,0,0,0,0,1,0,SUB,0));
        // ADDI, ORI, LUI
        addVec(6'h08, 6'h00, 1, cIF1);
        addVec(6'h08, 6'h00, 1, cID);
        addVec(6'h08, 6'h00, 1, mk(2,0,0,0,0,0,0,0,0,0,0,0,0,2,ADD,0));
        addVec(6'h08, 6'h00, 1, mk(4,0,0,0,0,0,0,0,0,1,0,0,0,0,ADD,0));
        addVec(6'h0D, 6'h00, 1, cIF1);
        addVec(6'h0D, 6'h00, 1, cID);
        addVec(6'h0D, 6'h00, 1, mk(2,0,0,0,0,0,0,0,0,0,0,0,0,2,ORA,0));
        addVec(6'h0D, 6'h00, 1, mk(4,0,0,0,0,0,0,0,0,1,0,0,0,0,ADD,0));
        addVec(6'h0F, 6'h00, 1, cIF1);
        addVec(6'h0F, 6'h00, 1, cID);
        addVec(6'h0F, 6'h00, 1, mk(2,0,0,0,0,0,0,0,0,0,0,0,0,2,LUI,0));
        addVec(6'h0F, 6'h00, 1, mk(4,0,0,0,0,0,0,0,0,1,0,0,0,0,ADD,0));

        // Reset held with ready high: fetch must not be requested.
        rstN     = 1'b0;
        instrOp  = 6'h00;
        funct    = 6'h00;
        memReady = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("resetHeld", cZero);
        memReady = 1'b0;
        @(negedge clk);
        rstN = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].op, vecs[i].funct, vecs[i].ready);
            checkOutput($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Illegal opcode traps and stays trapped regardless of inputs.
        applyStimulus(6'h3F, 6'h00, 1);
        checkOutput("trapIF", cIF1);
        applyStimulus(6'h3F, 6'h00, 1);
        checkOutput("trapID", cID);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(6'($urandom_range(0, 63)), 6'h20, 1'($urandom_range(0, 1)));
            checkOutput($sformatf("trapHold%0d", i), cTrap);
        end
        #2 rstN = 1'b0;
        checkOutput("trapReset", cZero);
        @(negedge clk);
        memReady = 1'b0;
        rstN     = 1'b1;

        // Reset asserted mid-MEM of a LW kills the read immediately.
        applyStimulus(6'h23, 6'h00, 1);
        checkOutput("lwIF", cIF1);
        applyStimulus(6'h23, 6'h00, 1);
        checkOutput("lwID", cID);
        applyStimulus(6'h23, 6'h00, 0);
        checkOutput("lwEX", mk(2,0,0,0,0,0,0,0,0,0,0,0,0,2,ADD,0));
        applyStimulus(6'h23, 6'h00, 0);
        checkOutput("lwMEM", mk(3,0,0,0,0,0,1,1,0,0,0,0,0,0,ADD,0));
        #2 rstN = 1'b0;
        checkOutput("midMemReset", cZero);
        @(negedge clk);
        rstN     = 1'b1;
        instrOp  = 6'h00;
        funct    = 6'h20;
        memReady = 1'b1;
        checkOutput("restartIF", cIF1);
        applyStimulus(6'h00, 6'h20, 1);
        checkOutput("restartID", cID);

`ifdef MC_PERF_CNT_EN
        // ADD, SW, J back to back at full speed: 10 cycles, 3 retirements.
        @(negedge clk);
        rstN = 1'b0;
        #1;
        checkValue("cycleReset", cycleCnt, 32'd0);
        checkValue("retiredReset", retiredCnt, 32'd0);
        @(negedge clk);
        rstN = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clk);
            instrOp  = (i < 4) ? 6'h00 : ((i < 8) ? 6'h2B : 6'h02);
            funct    = 6'h20;
            memReady = 1'b1;
        end
        @(negedge clk);
        #1;
        checkValue("cycleCnt", cycleCnt, 32'd10);
        checkValue("retiredCnt", retiredCnt, 32'd3);
`endif

        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule
